// File: rtl/router_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_fifo_pkg
//  Description : Shared constants and the packet-length helper for the
//                router FIFO.
//                DEPTH   - number of stored entries
//                DATA_W  - payload byte width
//                ENTRY_W - stored entry width ({header flag, byte})
//                PTR_W   - pointer width (index plus wrap flag)
//                CNT_W   - packet byte counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package router_fifo_pkg;

    localparam int DEPTH   = 16;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = 9;
    localparam int PTR_W   = 5;
    localparam int CNT_W   = 6;
    localparam int ADDR_W  = $clog2(DEPTH);

    // Remaining-bytes counter update on a read. A header byte carries the
    // payload length in bits 7:2; one extra byte is added for the parity
    // byte that trails every packet. Non-header bytes count down to zero.
    function automatic logic [CNT_W-1:0] next_count(
        input logic             is_header,
        input logic [CNT_W-1:0] length_field,
        input logic [CNT_W-1:0] cnt
    );
        logic [CNT_W-1:0] result;
        if (is_header) begin
            result = length_field + CNT_W'(1);
        end else if (cnt != '0) begin
            result = cnt - CNT_W'(1);
        end else begin
            result = cnt;
        end
        return result;
    endfunction

endpackage : router_fifo_pkg
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_fifo
//  Description : 16-entry byte FIFO for a packet router. Each entry stores
//                the byte plus a header flag; a counter tracks how many
//                bytes of the current packet remain to be read, and the
//                output returns to its idle value once a packet is drained.
//
//  Ports       : clock       - single clock, rising edge
//                resetn      - asynchronous reset, active-low
//                soft_reset  - synchronous flush, active-high
//                write_enb   - write request
//                read_enb    - read request
//                data_in     - byte to write
//                lfd_state   - data_in is a packet header byte
//                empty       - no stored entries
//                full        - all 16 entries stored
//                data_out    - registered read data
//
//  Config      : ROUTER_FIFO_HIZ_EN - when defined, the idle value of
//                data_out is high-impedance; otherwise it is 8'h00.
//                Asynchronous reset always drives 8'h00.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_fifo
    import router_fifo_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              write_enb,
    input  logic              soft_reset,
    input  logic              read_enb,
    input  logic [DATA_W-1:0] data_in,
    input  logic              lfd_state,
    output logic              empty,
    output logic [DATA_W-1:0] data_out,
    output logic              full
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   rp;
    logic [CNT_W-1:0]   count;
    logic [DATA_W-1:0]  r_data;

    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [ENTRY_W-1:0] w_rd_entry;

    // Pointers carry one wrap bit above the index so that equal indices
    // distinguish empty (same lap) from full (one lap apart).
    assign empty = (wp == rp);
    assign full  = (wp[PTR_W-1] != rp[PTR_W-1]) &&
                   (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);

    // Flags are evaluated on pre-edge pointers: a write while full is
    // dropped even when a read frees a slot in the same cycle.
    assign w_wr_ok    = write_enb & ~full;
    assign w_rd_ok    = read_enb & ~empty;
    assign w_rd_entry = mem[rp[ADDR_W-1:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            r_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (soft_reset) begin
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            r_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                mem[wp[ADDR_W-1:0]] <= {lfd_state, data_in};
                wp                  <= wp + PTR_W'(1);
            end
            if (w_rd_ok) begin
                r_data <= w_rd_entry[DATA_W-1:0];
                rp     <= rp + PTR_W'(1);
                count  <= next_count(w_rd_entry[ENTRY_W-1],
                                     w_rd_entry[DATA_W-1:2], count);
            end else if (count == '0) begin
                // Packet fully drained and nothing read: go idle. A read
                // attempt while empty mid-packet keeps the last byte.
                r_data <= '0;
            end
        end
    end

`ifdef ROUTER_FIFO_HIZ_EN
    // Tri-state is applied at the output through a registered idle flag so
    // that the stored byte register itself only ever holds real values.
    logic r_idle;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_idle <= 1'b0;
        end else if (soft_reset) begin
            r_idle <= 1'b1;
        end else if (w_rd_ok) begin
            r_idle <= 1'b0;
        end else if (count == '0) begin
            r_idle <= 1'b1;
        end
    end

    assign data_out = r_idle ? {DATA_W{1'bz}} : r_data;
`else
    assign data_out = r_data;
`endif

endmodule : router_fifo
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_fifo
//  Description : Self-checking bench for router_fifo. A queue-based model of
//                the FIFO contents, lap-counted pointers and the packet
//                byte counter predicts every observable value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       write_enb;
    logic       soft_reset;
    logic       read_enb;
    logic [7:0] data_in;
    logic       lfd_state;
    logic       empty;
    logic [7:0] data_out;
    logic       full;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .write_enb  (write_enb),
        .soft_reset (soft_reset),
        .read_enb   (read_enb),
        .data_in    (data_in),
        .lfd_state  (lfd_state),
        .empty      (empty),
        .data_out   (data_out),
        .full       (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef ROUTER_FIFO_HIZ_EN
    localparam logic [7:0] IDLE = 8'hzz;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [8:0] q_m[$];
    logic [8:0] mem_m [16];
    int         wr_total;
    int         rd_total;
    int         cnt_m;
    logic [7:0] dout_m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input logic [7:0] dout_val);
        q_m.delete();
        for (int i = 0; i < 16; i++) mem_m[i] = 9'h000;
        wr_total = 0;
        rd_total = 0;
        cnt_m    = 0;
        dout_m   = dout_val;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".empty"}, 16'(empty), 16'(q_m.size() == 0));
        chk({tag, ".full"},  16'(full),  16'(q_m.size() == 16));
        chk({tag, ".wp"},    16'(dut.wp), 16'(wr_total % 32));
        chk({tag, ".rp"},    16'(dut.rp), 16'(rd_total % 32));
        chk({tag, ".count"}, 16'(dut.count), 16'(cnt_m));
        chk({tag, ".dout"},  16'(data_out), 16'(dout_m));
    endtask

    // One clock: drive at the falling edge, predict, check 1 ns after the
    // rising edge.
    task automatic step(input logic we, input logic re, input logic [7:0] din,
                        input logic lfd, input logic srst, input string tag);
        logic       rd_ok;
        logic       wr_ok;
        logic [8:0] e;
        @(negedge clock);
        write_enb  = we;
        read_enb   = re;
        data_in    = din;
        lfd_state  = lfd;
        soft_reset = srst;
        if (srst) begin
            model_clear(IDLE);
        end else begin
            rd_ok = re && (q_m.size() != 0);
            wr_ok = we && (q_m.size() != 16);
            if (rd_ok) begin
                e = q_m.pop_front();
                dout_m = e[7:0];
                rd_total++;
                if (e[8])            cnt_m = ((e[7:0] >> 2) + 1) % 64;
                else if (cnt_m != 0) cnt_m = cnt_m - 1;
            end else if (cnt_m == 0) begin
                dout_m = IDLE;
            end
            if (wr_ok) begin
                q_m.push_back({lfd, din});
                mem_m[wr_total % 16] = {lfd, din};
                wr_total++;
            end
        end
        @(posedge clock);
        #1;
        check_all(tag);
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        soft_reset = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s.mem%0d", tag, i), 16'(dut.mem[i]), 16'(mem_m[i]));
        end
    endtask

    task automatic async_reset(input string tag);
        @(posedge clock);
        #3;
        resetn = 1'b0;
        model_clear(8'h00);
        #1;
        check_all(tag);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        resetn     = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        soft_reset = 1'b0;
        data_in    = 8'h00;
        lfd_state  = 1'b0;
        model_clear(8'h00);

        // Reset scenario
        repeat (2) @(posedge clock);
        #1;
        check_all("por");
        @(negedge clock);
        resetn = 1'b1;
        async_reset("rst_pulse");

        // Packet write/read: header 0x15 -> 5 payload bytes + parity
        step(1, 0, 8'h15, 1, 0, "pkt_hdr");
        for (int i = 0; i < 5; i++) step(1, 0, 8'hA1 + 8'(i), 0, 0, "pkt_pay");
        step(1, 0, 8'h5C, 0, 0, "pkt_par");
        chk("pkt.wp7", 16'(dut.wp), 16'd7);
        chk("pkt.mem0", 16'(dut.mem[0]), 16'h0115);
        for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0, 0, "pkt_rd");
        chk("pkt.empty_end", 16'(empty), 16'd1);
        step(0, 0, 8'h00, 0, 0, "pkt_idle");
        chk("pkt.idle_out", 16'(data_out), 16'(IDLE));

        // Fill, then overflow attempt
        step(0, 0, 8'h00, 0, 1, "fill_flush");
        for (int i = 0; i < 16; i++) step(1, 0, 8'($urandom), 1'($urandom), 0, "fill");
        chk("fill.full", 16'(full), 16'd1);
        chk("fill.wp", 16'(dut.wp), 16'h0010);
        step(1, 0, 8'hEE, 1, 0, "fill_ovf");
        chk("ovf.wp", 16'(dut.wp), 16'h0010);
        check_mem("ovf");

        // Wrap: 4 reads, 4 writes, then drain all 16
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0, "wrap_rd");
        for (int i = 0; i < 4; i++) step(1, 0, 8'($urandom), 1'($urandom), 0, "wrap_wr");
        chk("wrap.wp", 16'(dut.wp), 16'h0014);
        chk("wrap.rp", 16'(dut.rp), 16'h0004);
        chk("wrap.full", 16'(full), 16'd1);
        check_mem("wrap");
        // Simultaneous read+write while full: read happens, write dropped
        step(1, 1, 8'h77, 0, 0, "full_rw");
        for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0, 0, "wrap_drain");
        chk("wrap.empty", 16'(empty), 16'd1);

        // Soft reset after 3 writes, with read/write also requested
        for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom), 0, 0, "srst_wr");
        step(1, 1, 8'h99, 1, 1, "srst");
        chk("srst.wp", 16'(dut.wp), 16'd0);
        chk("srst.dout", 16'(data_out), 16'(IDLE));
        check_mem("srst");

        // Underflow mid-packet: data_out holds the last byte
        step(1, 0, 8'h14, 1, 0, "uf_hdr");
        step(0, 1, 8'h00, 0, 0, "uf_rd");
        step(0, 1, 8'h00, 0, 0, "uf_empty_rd");
        chk("uf.hold", 16'(data_out), 16'h0014);
        chk("uf.rp", 16'(dut.rp), 16'd1);
        // Underflow with packet finished: output goes idle
        step(0, 0, 8'h00, 0, 1, "uf_flush");
        step(0, 1, 8'h00, 0, 0, "uf_idle_rd");

        // Randomized traffic with write-heavy, read-heavy and mixed phases
        for (int i = 0; i < 600; i++) begin
            int  ph;
            logic we;
            logic re;
            ph = i / 200;
            we = (ph == 0) ? ($urandom_range(0, 3) != 0) :
                 (ph == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            re = (ph == 0) ? ($urandom_range(0, 3) == 0) :
                 (ph == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom);
            step(we, re, 8'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 99) == 0), "rand");
        end

        // Asynchronous reset mid-packet, then first write lands at mem[0]
        step(1, 0, 8'h20, 1, 0, "mid_hdr");
        step(1, 1, 8'h31, 0, 0, "mid_rw");
        async_reset("mid_rst");
        step(1, 0, 8'h42, 0, 0, "post_rst_wr");
        chk("post_rst.mem0", 16'(dut.mem[0]), 16'h0042);
        check_mem("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_router_fifo
`default_nettype wire

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL expose: clock  input  1  single clock, all state updates on rising edge.
REQ-002 The block SHALL expose: resetn  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL expose: write_enb  input  1  write request.
REQ-004 The block SHALL expose: soft_reset  input  1  synchronous flush, active-high.
REQ-005 The block SHALL expose: read_enb  input  1  read request.
REQ-006 The block SHALL expose: data_in  input  8  byte to write.
REQ-007 The block SHALL expose: lfd_state  input  1  marks data_in as a packet header byte.
REQ-008 The block SHALL expose: empty  output  1  no stored entries.
REQ-009 The block SHALL expose: data_out  output  8  registered read data.
REQ-010 The block SHALL expose: full  output  1  16 entries stored.

Function
REQ-011 Storage SHALL be an array mem of 16 x 9-bit entries, with bit 8 = lfd_state and bits 7:0 = data_in.
REQ-012 Pointers wp and rp SHALL be 5 bits: bits 3:0 index mem, bit 4 is a wrap flag; both increment modulo 32.
REQ-013 empty SHALL be combinational, asserted when wp == rp.
REQ-014 full SHALL be combinational, asserted when wp[4] != rp[4] and wp[3:0] == rp[3:0].
REQ-015 Write: at a rising edge with write_enb=1 and full=0, mem[wp[3:0]] <= {lfd_state, data_in} and wp increments; a write while full SHALL be dropped with no state change.
REQ-016 Read: at a rising edge with read_enb=1 and empty=0, data_out <= mem[rp[3:0]][7:0] and rp increments; a read while empty SHALL leave rp and data_out unchanged.
REQ-017 Simultaneous read and write SHALL both execute in the same cycle; full and empty are evaluated on pre-edge pointers, so a write while full is dropped even if a read occurs.
REQ-018 A 6-bit packet counter count SHALL track the remaining bytes of the packet being read.
REQ-019 On a read of an entry with bit 8 = 1, count SHALL load entry[7:2] + 1 (payload length plus parity).
REQ-020 On a read of an entry with bit 8 = 0 and count != 0, count SHALL decrement by 1.
REQ-021 In any cycle without a valid read and with count == 0, data_out SHALL take its idle value (see REQ-027).
REQ-022 Priority SHALL be: resetn, then soft_reset, then read/write.

Reset
REQ-023 While resetn=0, regardless of clock: wp=0, rp=0, count=0, all mem entries=0, and data_out=8'h00; therefore empty=1 and full=0.
REQ-024 soft_reset=1 at a rising edge SHALL clear wp, rp, count and all mem entries, and set data_out to its idle value; writes and reads in that cycle are ignored.
REQ-025 Reset asserted mid-packet SHALL discard all stored data; after release, the first write lands at mem[0].

Configuration
REQ-026 The macro ROUTER_FIFO_HIZ_EN SHALL select the data_out idle value.
REQ-027 With ROUTER_FIFO_HIZ_EN defined, the idle value SHALL be 8'hZZ (tri-state); without it, the idle value SHALL be 8'h00; asynchronous reset always drives 8'h00.

Structure
REQ-028 A package router_fifo_pkg SHALL hold the constants DEPTH=16, DATA_W=8, ENTRY_W=9, PTR_W=5 and CNT_W=6.
REQ-029 The design SHALL be a single flat module; no sub-module, with internal names mem, wp and rp kept for hierarchical probing.

Verification
REQ-030 Scenario, reset: pulse resetn low -> empty=1, full=0, wp=0, rp=0, data_out=8'h00.
REQ-031 Scenario, packet write/read: write header 8'h15 with lfd=1, then 5 payload bytes and 1 parity byte with lfd=0 -> wp=7, mem[0]=9'h115; 7 reads return the bytes in order, count goes 6,5,...,0, empty=1; the following idle cycle gives data_out=Z (macro on) or 8'h00 (macro off).
REQ-032 Scenario, fill: 16 writes -> full=1, wp=5'b10000; a 17th write is dropped, wp and mem unchanged.
REQ-033 Scenario, wrap: 16 writes, 4 reads, 4 writes -> wp=5'b10100, rp=5'b00100, full=1; 16 reads return all data in write order, with empty=1 at the end.
REQ-034 Scenario, soft reset: soft_reset=1 for one cycle after 3 writes -> wp=rp=0, empty=1, data_out=idle value.
REQ-035 Scenario, read underflow: read_enb=1 while empty -> rp unchanged and data_out holds its value.
